// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX/MEM, MEM/WB operand forwarding.
// A flush or load-use stall squashes the incoming instruction into a bubble.
module id_ex_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        id_valid,
   input  logic [31:0] id_rs_data,
   input  logic [31:0] id_rt_data,
   input  logic [31:0] id_imm,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic [2:0]  id_alu_ctrl,
   input  logic        id_alu_src,
   input  logic        id_dest_rt,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        exm_reg_write,
   input  logic [4:0]  exm_rd,
   input  logic [31:0] exm_result,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        flush,
   output logic [31:0] op1,
   output logic [31:0] op2,
   output logic [2:0]  alu_control,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_dest,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_valid,
   output logic        stall_if,
   output logic [15:0] stall_count
);

   typedef struct packed {
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic [2:0]  ctrl;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        valid;
   } stage_t;

   stage_t      stage_q, stage_d;
   logic [15:0] stall_count_q, stall_count_d;
   logic [31:0] fwd_rs, fwd_rt;

   // EX/MEM wins over MEM/WB; register 0 is never forwarded.
   function automatic logic [31:0] forward(
      input logic [4:0]  reg_num,
      input logic [31:0] reg_data,
      input logic        exm_we,
      input logic [4:0]  exm_num,
      input logic [31:0] exm_val,
      input logic        wb_we,
      input logic [4:0]  wb_num,
      input logic [31:0] wb_val
   );
      logic [31:0] result;
      result = reg_data;
      if (exm_we && exm_num != 5'd0 && exm_num == reg_num)
         result = exm_val;
      else if (wb_we && wb_num != 5'd0 && wb_num == reg_num)
         result = wb_val;
      return result;
   endfunction

   always_comb begin
      stall_if = stage_q.valid && stage_q.mem_read && (stage_q.dest != 5'd0) && id_valid &&
                 ((id_rs == stage_q.dest) || (id_rt == stage_q.dest)) && !flush;

      stage_d = '0;
      if (!flush && !stall_if) begin
         stage_d.rs_data   = id_rs_data;
         stage_d.rt_data   = id_rt_data;
         stage_d.imm       = id_imm;
         stage_d.rs        = id_rs;
         stage_d.rt        = id_rt;
         stage_d.dest      = id_dest_rt ? id_rt : id_rd;
         stage_d.ctrl      = id_alu_ctrl;
         stage_d.alu_src   = id_alu_src;
         stage_d.reg_write = id_reg_write & id_valid;
         stage_d.mem_read  = id_mem_read & id_valid;
         stage_d.mem_write = id_mem_write & id_valid;
         stage_d.valid     = id_valid;
      end

      stall_count_d = stall_count_q;
      if (stall_if && stall_count_q != 16'hFFFF)
         stall_count_d = stall_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q       <= '0;
         stall_count_q <= '0;
      end else begin
         stage_q       <= stage_d;
         stall_count_q <= stall_count_d;
      end
   end

   always_comb begin
      fwd_rs = forward(stage_q.rs, stage_q.rs_data, exm_reg_write, exm_rd, exm_result,
                       wb_reg_write, wb_rd, wb_data);
      fwd_rt = forward(stage_q.rt, stage_q.rt_data, exm_reg_write, exm_rd, exm_result,
                       wb_reg_write, wb_rd, wb_data);
   end

   assign op1           = fwd_rs;
   assign op2           = stage_q.alu_src ? stage_q.imm : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign alu_control   = stage_q.ctrl;
   assign ex_dest       = stage_q.dest;
   assign ex_reg_write  = stage_q.reg_write;
   assign ex_mem_read   = stage_q.mem_read;
   assign ex_mem_write  = stage_q.mem_write;
   assign ex_valid      = stage_q.valid;
   assign stall_count   = stall_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-cycle behaviour plus
// hand-written sequences for load-use stalls, flush, mid-stall reset and counter saturation.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [2:0]  id_alu_ctrl;
   logic        id_alu_src, id_dest_rt, id_reg_write, id_mem_read, id_mem_write;
   logic        exm_reg_write;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic [31:0] op1, op2, ex_store_data;
   logic [2:0]  alu_control;
   logic [4:0]  ex_dest;
   logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, stall_if;
   logic [15:0] stall_count;

   int vectors_applied = 0;
   int miscompares     = 0;

   id_ex_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
      .id_alu_src(id_alu_src), .id_dest_rt(id_dest_rt), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .op1(op1), .op2(op2), .alu_control(alu_control), .ex_store_data(ex_store_data),
      .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_valid(ex_valid), .stall_if(stall_if),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] rs_data, rt_data, imm;
      logic [4:0]  rs, rt, rd;
      logic [2:0]  ctrl;
      logic        alu_src, dest_rt, reg_write, mem_read, mem_write;
      logic        exm_we;
      logic [4:0]  exm_rd;
      logic [31:0] exm_res;
      logic        wb_we;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
      logic        flush;
      logic [31:0] e_op1, e_op2, e_store;
      logic [2:0]  e_ctrl;
      logic [4:0]  e_dest;
      logic        e_rw, e_mr, e_mw, e_valid, e_stall;
   } vec_t;

   vec_t vecs[10];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors_applied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      id_valid      = v.valid;
      id_rs_data    = v.rs_data;
      id_rt_data    = v.rt_data;
      id_imm        = v.imm;
      id_rs         = v.rs;
      id_rt         = v.rt;
      id_rd         = v.rd;
      id_alu_ctrl   = v.ctrl;
      id_alu_src    = v.alu_src;
      id_dest_rt    = v.dest_rt;
      id_reg_write  = v.reg_write;
      id_mem_read   = v.mem_read;
      id_mem_write  = v.mem_write;
      exm_reg_write = v.exm_we;
      exm_rd        = v.exm_rd;
      exm_result    = v.exm_res;
      wb_reg_write  = v.wb_we;
      wb_rd         = v.wb_rd;
      wb_data       = v.wb_data;
      flush         = v.flush;
   endtask

   task automatic clearInputs();
      id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
      id_rs = 0; id_rt = 0; id_rd = 0; id_alu_ctrl = 0;
      id_alu_src = 0; id_dest_rt = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
      exm_reg_write = 0; exm_rd = 0; exm_result = 0;
      wb_reg_write = 0; wb_rd = 0; wb_data = 0; flush = 0;
   endtask

   task automatic doReset();
      @(negedge clk);
      clearInputs();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // lw r8, 0(r1): enters EX on the following edge
   task automatic loadLw();
      @(negedge clk);
      clearInputs();
      id_valid = 1; id_rs = 5'd1; id_rt = 5'd8; id_dest_rt = 1;
      id_mem_read = 1; id_reg_write = 1;
      @(posedge clk);
      #1;
   endtask

   // add r3, r8, r2 in decode, dependent on the load in EX
   task automatic setHazard(input logic flush_val);
      @(negedge clk);
      clearInputs();
      id_valid = 1; id_rs = 5'd8; id_rt = 5'd2; id_rd = 5'd3; id_reg_write = 1;
      flush = flush_val;
      #1;
   endtask

   initial begin
      // order: valid, rs_data, rt_data, imm, rs, rt, rd, ctrl, alu_src, dest_rt, rw, mr, mw,
      //        exm_we, exm_rd, exm_res, wb_we, wb_rd, wb_data, flush,
      //        e_op1, e_op2, e_store, e_ctrl, e_dest, e_rw, e_mr, e_mw, e_valid, e_stall
      vecs[0] = '{1, 32'd5, 32'd7, 32'h100, 5'd1, 5'd2, 5'd3, 3'd0, 0, 0, 1, 0, 0,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0,
                  32'd5, 32'd7, 32'd7, 3'd0, 5'd3, 1, 0, 0, 1, 0};
      vecs[1] = '{1, 32'd10, 32'd20, 32'hFFFF_FFF0, 5'd4, 5'd5, 5'd6, 3'd4, 1, 1, 1, 0, 0,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0,
                  32'd10, 32'hFFFF_FFF0, 32'd20, 3'd4, 5'd5, 1, 0, 0, 1, 0};
      vecs[2] = '{1, 32'h11, 32'h22, 32'h0, 5'd3, 5'd9, 5'd10, 3'd1, 0, 0, 1, 0, 0,
                  1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB, 0,
                  32'hAA, 32'h22, 32'h22, 3'd1, 5'd10, 1, 0, 0, 1, 0};
      vecs[3] = '{1, 32'h11, 32'h22, 32'h0, 5'd3, 5'd9, 5'd10, 3'd1, 0, 0, 1, 0, 0,
                  0, 5'd3, 32'hAA, 1, 5'd3, 32'hBB, 0,
                  32'hBB, 32'h22, 32'h22, 3'd1, 5'd10, 1, 0, 0, 1, 0};
      vecs[4] = '{1, 32'h11, 32'h22, 32'h0, 5'd3, 5'd9, 5'd10, 3'd5, 0, 0, 1, 0, 0,
                  1, 5'd3, 32'hAA, 1, 5'd9, 32'hCC, 0,
                  32'hAA, 32'hCC, 32'hCC, 3'd5, 5'd10, 1, 0, 0, 1, 0};
      vecs[5] = '{1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 3'd3, 0, 0, 1, 0, 0,
                  1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'h1234_5678, 0,
                  32'h0, 32'h0, 32'h0, 3'd3, 5'd4, 1, 0, 0, 1, 0};
      vecs[6] = '{0, 32'h55, 32'h66, 32'h0, 5'd1, 5'd2, 5'd7, 3'd2, 0, 0, 1, 1, 1,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0,
                  32'h55, 32'h66, 32'h66, 3'd2, 5'd7, 0, 0, 0, 0, 0};
      vecs[7] = '{1, 32'h1000, 32'hDEAD, 32'h8, 5'd1, 5'd2, 5'd0, 3'd0, 1, 1, 0, 0, 1,
                  1, 5'd2, 32'hBEEF, 0, 5'd0, 32'h0, 0,
                  32'h1000, 32'h8, 32'hBEEF, 3'd0, 5'd2, 0, 0, 1, 1, 0};
      vecs[8] = '{1, 32'h77, 32'h88, 32'h9, 5'd1, 5'd2, 5'd3, 3'd6, 1, 0, 1, 1, 1,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1,
                  32'h0, 32'h0, 32'h0, 3'd0, 5'd0, 0, 0, 0, 0, 0};
      vecs[9] = '{1, 32'h200, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0, 3'd0, 1, 1, 1, 1, 0,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0,
                  32'h200, 32'h4, 32'h0, 3'd0, 5'd8, 1, 1, 0, 1, 1};

      reset = 1'b1;
      clearInputs();
      doReset();

      $display("[TB] reset state");
      checkOutput("rst_op1", op1, 32'h0);
      checkOutput("rst_op2", op2, 32'h0);
      checkOutput("rst_store", ex_store_data, 32'h0);
      checkOutput("rst_ctrl", {29'd0, alu_control}, 32'h0);
      checkOutput("rst_dest", {27'd0, ex_dest}, 32'h0);
      checkOutput("rst_flags", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_valid}, 32'h0);
      checkOutput("rst_stall", {31'd0, stall_if}, 32'h0);
      checkOutput("rst_count", {16'd0, stall_count}, 32'h0);

      $display("[TB] vector table");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d_op1", i), op1, vecs[i].e_op1);
         checkOutput($sformatf("v%0d_op2", i), op2, vecs[i].e_op2);
         checkOutput($sformatf("v%0d_store", i), ex_store_data, vecs[i].e_store);
         checkOutput($sformatf("v%0d_ctrl", i), {29'd0, alu_control}, {29'd0, vecs[i].e_ctrl});
         checkOutput($sformatf("v%0d_dest", i), {27'd0, ex_dest}, {27'd0, vecs[i].e_dest});
         checkOutput($sformatf("v%0d_flags", i),
                     {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_valid},
                     {28'd0, vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_valid});
         checkOutput($sformatf("v%0d_stall", i), {31'd0, stall_if}, {31'd0, vecs[i].e_stall});
      end

      $display("[TB] load-use stall");
      doReset();
      loadLw();
      setHazard(1'b0);
      checkOutput("lu_stall", {31'd0, stall_if}, 32'd1);
      @(posedge clk);
      #1;
      checkOutput("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
      checkOutput("lu_bubble_mr", {31'd0, ex_mem_read}, 32'd0);
      checkOutput("lu_count", {16'd0, stall_count}, 32'd1);
      checkOutput("lu_stall_drop", {31'd0, stall_if}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("lu_add_valid", {31'd0, ex_valid}, 32'd1);
      checkOutput("lu_add_dest", {27'd0, ex_dest}, 32'd3);
      checkOutput("lu_count_hold", {16'd0, stall_count}, 32'd1);

      $display("[TB] flush with hazard");
      doReset();
      loadLw();
      setHazard(1'b1);
      checkOutput("fl_stall", {31'd0, stall_if}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("fl_valid", {31'd0, ex_valid}, 32'd0);
      checkOutput("fl_dest", {27'd0, ex_dest}, 32'd0);
      checkOutput("fl_count", {16'd0, stall_count}, 32'd0);

      $display("[TB] reset during stall");
      doReset();
      loadLw();
      setHazard(1'b0);
      checkOutput("rs_stall_pre", {31'd0, stall_if}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("rs_stall_post", {31'd0, stall_if}, 32'd0);
      checkOutput("rs_valid", {31'd0, ex_valid}, 32'd0);
      checkOutput("rs_count", {16'd0, stall_count}, 32'd0);

      $display("[TB] stall counter");
      doReset();
      for (int i = 0; i < 20; i++) begin
         loadLw();
         setHazard(1'b0);
         @(posedge clk);
         #1;
      end
      checkOutput("cnt_20", {16'd0, stall_count}, 32'd20);

      // preload the counter near its ceiling rather than spending 131k cycles on stalls
      @(negedge clk);
      force dut.stall_count_q = 16'hFFFD;
      #1;
      release dut.stall_count_q;
      #1;
      checkOutput("sat_preload", {16'd0, stall_count}, 32'hFFFD);
      for (int i = 0; i < 3; i++) begin
         loadLw();
         setHazard(1'b0);
         @(posedge clk);
         #1;
         checkOutput($sformatf("sat_%0d", i), {16'd0, stall_count},
                     (i == 0) ? 32'hFFFE : 32'hFFFF);
      end
      doReset();
      checkOutput("sat_reset", {16'd0, stall_count}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter-free ports listed below; all buses are unsigned vectors, bit 0 = LSB.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 id_valid  in  1  decode stage holds a real instruction.
REQ-005 id_rs_data, id_rt_data  in  32 each  register-file read data.
REQ-006 id_imm  in  32  sign-extended immediate.
REQ-007 id_rs, id_rt, id_rd  in  5 each  source/destination register numbers.
REQ-008 id_alu_ctrl  in  3  ALU operation code (000 ADD, 001 SUB, 010 SHIFT, 011 AND, 100 OR, 101 XOR, 110 NOR).
REQ-009 id_alu_src, id_dest_rt, id_reg_write, id_mem_read, id_mem_write  in  1 each  op2=imm select, dest=rt select, control flags.
REQ-010 exm_reg_write  in  1; exm_rd  in  5; exm_result  in  32  EX/MEM forwarding source.
REQ-011 wb_reg_write  in  1; wb_rd  in  5; wb_data  in  32  MEM/WB forwarding source.
REQ-012 flush  in  1  squash instruction entering EX (taken branch / jump).
REQ-013 op1, op2  out  32  ALU operands; alu_control  out  3  ALU op code.
REQ-014 ex_store_data  out  32; ex_dest  out  5; ex_reg_write, ex_mem_read, ex_mem_write, ex_valid  out  1 each.
REQ-015 stall_if  out  1  hold PC and IF/ID register this cycle.
REQ-016 stall_count  out  16  load-use stall cycles since reset.

Function
REQ-017 Stage register (rs/rt data, imm, rs, rt, dest, ctrl, flags, valid) SHALL update every edge; priority reset > flush > stall > load.
REQ-018 Load: capture id_* fields; dest = id_dest_rt ? id_rt : id_rd; ex_valid = id_valid; flags ANDed with id_valid.
REQ-019 Flush or stall: load a bubble -- all fields zero, ex_valid=0, alu_control=000.
REQ-020 Latency: id_* values at edge N appear on outputs after edge N, one cycle.
REQ-021 Load-use hazard (comb): stall_if=1 iff ex_valid & ex_mem_read & ex_dest!=0 & id_valid & (id_rs==ex_dest | id_rt==ex_dest) & !flush.
REQ-022 flush=1 SHALL force stall_if=0 in the same cycle.
REQ-023 Forwarding (comb, per operand, on registered rs/rt): exm_reg_write & exm_rd!=0 & exm_rd==reg -> exm_result; else wb_reg_write & wb_rd!=0 & wb_rd==reg -> wb_data; else registered data.
REQ-024 EX/MEM match SHALL win over MEM/WB match for the same register.
REQ-025 Register 0 SHALL never be forwarded; its operand is the registered data.
REQ-026 op1 = forwarded rs; op2 = alu_src ? imm : forwarded rt; ex_store_data = forwarded rt; alu_control = registered ctrl.
REQ-027 stall_count SHALL increment by 1 on each edge where stall_if=1 and reset=0, saturating at 0xFFFF.

Reset
REQ-028 With reset high at an edge: all stage fields zero, ex_valid=0, ex_dest=0, flags 0, alu_control=000, stall_count=0.
REQ-029 After reset with no forwarding match: op1=op2=ex_store_data=0; stall_if=0.
REQ-030 Reset asserted mid-stall SHALL clear the bubble/hazard state; stall_if drops once ex_mem_read=0 is registered.

Verification
REQ-031 ADD: id_rs_data=5, id_rt_data=7, ctrl=000, alu_src=0, no matches -> next cycle op1=5, op2=7, alu_control=000, ex_valid=1.
REQ-032 Double forward: registered rs=3; exm_rd=3 result=0xAA, wb_rd=3 data=0xBB, both write -> op1=0xAA; exm_reg_write=0 -> op1=0xBB.
REQ-033 R0: exm_rd=0, exm_reg_write=1, exm_result=0xFFFF_FFFF, rs=0, rs_data=0 -> op1=0.
REQ-034 Load-use: EX holds lw dest=8; id_rs=8, id_valid=1 -> stall_if=1, next cycle ex_valid=0, stall_count=1; following cycle stall_if=0.
REQ-035 Flush+hazard: same as REQ-034 with flush=1 -> stall_if=0, bubble loaded, stall_count unchanged.
REQ-036 Saturation: force 65,536 stall cycles -> stall_count=0xFFFF, holds; reset -> 0.
